// File: rtl/connect6_pkg.sv
// Shared Connect6 definitions: move-parser state encoding, packet header
// byte, board dimension and a coordinate range helper.
package connect6_pkg;

  localparam logic [7:0] HEADER_BYTE        = 8'hA5;
  localparam int         BOARD_SIZE_DEFAULT = 19;
  localparam int         COORD_W            = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_X1    = 3'd2,
    ST_Y1    = 3'd3,
    ST_X2    = 3'd4,
    ST_Y2    = 3'd5,
    ST_CHK   = 3'd6,
    ST_HOLD  = 3'd7
  } rx_state_t;

  // A coordinate byte is legal when it lies in 0..limit-1.
  function automatic logic coord_in_range(input logic [7:0] b, input logic [7:0] limit);
    return (b < limit);
  endfunction

endpackage

// File: rtl/rx_timeout_counter.sv
// Inter-byte gap counter. Counts enabled cycles since the last clear and
// saturates at TIMEOUT; expired is high while the count sits at TIMEOUT.
module rx_timeout_counter #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count_r;

  // Gap count register: clear wins, otherwise count up and stick at LIMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != LIMIT)) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LIMIT);

endmodule

// File: rtl/move_rx_parser.sv
// Parses opponent-move packets (HEADER, COUNT, X1, Y1, [X2, Y2], CHK) from a
// UART byte stream, validates them and presents the move to the game board.
module move_rx_parser
  import connect6_pkg::*;
#(
  parameter int         BOARD_SIZE = BOARD_SIZE_DEFAULT,
  parameter logic [7:0] HEADER     = HEADER_BYTE,
  parameter int         TIMEOUT    = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic               board_ready,
  output logic [COORD_W-1:0] x_1,
  output logic [COORD_W-1:0] y_1,
  output logic [COORD_W-1:0] x_2,
  output logic [COORD_W-1:0] y_2,
  output logic               stones,
  output logic               move_valid,
  output logic               err_format,
  output logic               err_checksum,
  output logic               err_timeout,
  output logic               err_overrun
);

  localparam logic [7:0] BOARD_LIM = 8'(BOARD_SIZE);

  rx_state_t          state_r, state_nxt_s;
  logic [7:0]         xor_r, xor_nxt_s;
  logic               two_r, two_nxt_s;
  logic [COORD_W-1:0] px1_r, py1_r, px2_r, py2_r;
  logic [COORD_W-1:0] px1_nxt_s, py1_nxt_s, px2_nxt_s, py2_nxt_s;
  logic [COORD_W-1:0] x1_nxt_s, y1_nxt_s, x2_nxt_s, y2_nxt_s;
  logic               stones_nxt_s, mv_nxt_s;
  logic               fmt_nxt_s, chk_nxt_s, to_nxt_s, ovr_nxt_s;
  logic               in_pkt_s, expired_s, coord_ok_s;
  logic [COORD_W-1:0] coord_s;
  logic [7:0]         xor_upd_s;

  assign in_pkt_s   = (state_r != ST_IDLE) && (state_r != ST_HOLD);
  assign coord_ok_s = coord_in_range(rx_data, BOARD_LIM);
  assign coord_s    = rx_data[COORD_W-1:0];
  assign xor_upd_s  = xor_r ^ rx_data;

  // Gap counter restarts on every byte and stays cleared outside a packet.
  rx_timeout_counter #(.TIMEOUT(TIMEOUT)) u_gap (
    .clk     (clk),
    .reset   (reset),
    .clear   (rx_valid | ~in_pkt_s),
    .enable  (in_pkt_s),
    .expired (expired_s)
  );

  // Next-state and datapath decode; a byte in the expiry cycle beats the timeout.
  always_comb begin
    state_nxt_s  = state_r;
    xor_nxt_s    = xor_r;
    two_nxt_s    = two_r;
    px1_nxt_s    = px1_r;
    py1_nxt_s    = py1_r;
    px2_nxt_s    = px2_r;
    py2_nxt_s    = py2_r;
    x1_nxt_s     = x_1;
    y1_nxt_s     = y_1;
    x2_nxt_s     = x_2;
    y2_nxt_s     = y_2;
    stones_nxt_s = stones;
    mv_nxt_s     = move_valid;
    fmt_nxt_s    = 1'b0;
    chk_nxt_s    = 1'b0;
    to_nxt_s     = 1'b0;
    ovr_nxt_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        mv_nxt_s = 1'b0;
        if (rx_valid && (rx_data == HEADER)) begin
          xor_nxt_s   = HEADER;
          state_nxt_s = ST_COUNT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (rx_valid) begin
          if ((rx_data == 8'd1) || (rx_data == 8'd2)) begin
            two_nxt_s   = (rx_data == 8'd2);
            xor_nxt_s   = xor_upd_s;
            state_nxt_s = ST_X1;
          end else begin
            fmt_nxt_s   = 1'b1;
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_COUNT;
        end
      end
      ST_X1: begin
        if (rx_valid) begin
          if (coord_ok_s) begin
            px1_nxt_s   = coord_s;
            xor_nxt_s   = xor_upd_s;
            state_nxt_s = ST_Y1;
          end else begin
            fmt_nxt_s   = 1'b1;
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_X1;
        end
      end
      ST_Y1: begin
        if (rx_valid) begin
          if (coord_ok_s) begin
            py1_nxt_s   = coord_s;
            xor_nxt_s   = xor_upd_s;
            state_nxt_s = two_r ? ST_X2 : ST_CHK;
          end else begin
            fmt_nxt_s   = 1'b1;
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_Y1;
        end
      end
      ST_X2: begin
        if (rx_valid) begin
          if (coord_ok_s) begin
            px2_nxt_s   = coord_s;
            xor_nxt_s   = xor_upd_s;
            state_nxt_s = ST_Y2;
          end else begin
            fmt_nxt_s   = 1'b1;
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_X2;
        end
      end
      ST_Y2: begin
        if (rx_valid) begin
          if (!coord_ok_s || ((px1_r == px2_r) && (py1_r == coord_s))) begin
            // Out of range, or both stones on the same point.
            fmt_nxt_s   = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            py2_nxt_s   = coord_s;
            xor_nxt_s   = xor_upd_s;
            state_nxt_s = ST_CHK;
          end
        end else begin
          state_nxt_s = ST_Y2;
        end
      end
      ST_CHK: begin
        if (rx_valid) begin
          if (rx_data == xor_r) begin
            x1_nxt_s     = px1_r;
            y1_nxt_s     = py1_r;
            x2_nxt_s     = two_r ? px2_r : {COORD_W{1'b0}};
            y2_nxt_s     = two_r ? py2_r : {COORD_W{1'b0}};
            stones_nxt_s = two_r;
            mv_nxt_s     = 1'b1;
            state_nxt_s  = ST_HOLD;
          end else begin
            chk_nxt_s   = 1'b1;
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_CHK;
        end
      end
      ST_HOLD: begin
        ovr_nxt_s = rx_valid;
        if (board_ready) begin
          mv_nxt_s    = 1'b0;
          state_nxt_s = ST_IDLE;
        end else begin
          mv_nxt_s    = 1'b1;
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        mv_nxt_s    = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase

    if (in_pkt_s && !rx_valid && expired_s) begin
      to_nxt_s    = 1'b1;
      state_nxt_s = ST_IDLE;
    end else begin
      to_nxt_s    = 1'b0;
    end
  end

  // State, accumulator and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      xor_r        <= 8'h00;
      two_r        <= 1'b0;
      px1_r        <= '0;
      py1_r        <= '0;
      px2_r        <= '0;
      py2_r        <= '0;
      x_1          <= '0;
      y_1          <= '0;
      x_2          <= '0;
      y_2          <= '0;
      stones       <= 1'b0;
      move_valid   <= 1'b0;
      err_format   <= 1'b0;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      xor_r        <= xor_nxt_s;
      two_r        <= two_nxt_s;
      px1_r        <= px1_nxt_s;
      py1_r        <= py1_nxt_s;
      px2_r        <= px2_nxt_s;
      py2_r        <= py2_nxt_s;
      x_1          <= x1_nxt_s;
      y_1          <= y1_nxt_s;
      x_2          <= x2_nxt_s;
      y_2          <= y2_nxt_s;
      stones       <= stones_nxt_s;
      move_valid   <= mv_nxt_s;
      err_format   <= fmt_nxt_s;
      err_checksum <= chk_nxt_s;
      err_timeout  <= to_nxt_s;
      err_overrun  <= ovr_nxt_s;
    end
  end

endmodule

// File: tb/tb_move_rx_parser.sv
// Directed bench for move_rx_parser: hand-computed packets and expectations.
module tb_move_rx_parser;

  localparam int TO = 1000;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       board_ready;
  logic [5:0] x_1, y_1, x_2, y_2;
  logic       stones, move_valid;
  logic       err_format, err_checksum, err_timeout, err_overrun;

  int n_assert = 0;
  int n_fail   = 0;
  int mv_cnt   = 0;
  int fmt_cnt  = 0;
  int chk_cnt  = 0;
  int to_cnt   = 0;
  int ovr_cnt  = 0;

  move_rx_parser #(.BOARD_SIZE(19), .HEADER(8'hA5), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .board_ready  (board_ready),
    .x_1          (x_1),
    .y_1          (y_1),
    .x_2          (x_2),
    .y_2          (y_2),
    .stones       (stones),
    .move_valid   (move_valid),
    .err_format   (err_format),
    .err_checksum (err_checksum),
    .err_timeout  (err_timeout),
    .err_overrun  (err_overrun)
  );

  always #5 clk = ~clk;

  // Count high cycles of every pulse/strobe output, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (move_valid)   mv_cnt  <= mv_cnt + 1;
      if (err_format)   fmt_cnt <= fmt_cnt + 1;
      if (err_checksum) chk_cnt <= chk_cnt + 1;
      if (err_timeout)  to_cnt  <= to_cnt + 1;
      if (err_overrun)  ovr_cnt <= ovr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Send n bytes taken MSB-first from a 64-bit vector, one idle cycle between bytes.
  task automatic send_pkt(input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) begin
      send_byte(bytes[63-8*i -: 8]);
      if (i != n - 1) tick();
    end
  endtask

  initial begin
    reset       = 1'b1;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    board_ready = 1'b1;

    // Reset state
    idle(3);
    check("rst_outs_in_reset", 32'({x_1, y_1, x_2, y_2, stones, move_valid,
          err_format, err_checksum, err_timeout, err_overrun}), 32'd0);
    reset = 1'b0;
    idle(2);
    check("rst_outs_after", 32'({x_1, y_1, x_2, y_2, stones, move_valid,
          err_format, err_checksum, err_timeout, err_overrun}), 32'd0);

    // Two stones, board already ready: one-cycle move_valid
    send_pkt({8'hA5, 8'h02, 8'h03, 8'h04, 8'h0A, 8'h0B, 8'hA1, 8'h00}, 7);
    check("a_mv_rise", 32'(move_valid), 32'd1);
    check("a_coords", 32'({x_1, y_1, x_2, y_2, stones}),
          32'({6'd3, 6'd4, 6'd10, 6'd11, 1'b1}));
    idle(1);
    check("a_mv_fall", 32'(move_valid), 32'd0);
    idle(2);
    check("a_mv_cycles", 32'(mv_cnt), 32'd1);

    // One stone, board busy for 5 cycles, byte arriving during hold
    board_ready = 1'b0;
    send_pkt({8'hA5, 8'h01, 8'h09, 8'h09, 8'hA4, 24'h0}, 5);
    check("b_mv_rise", 32'(move_valid), 32'd1);
    check("b_coords", 32'({x_1, y_1, x_2, y_2, stones}),
          32'({6'd9, 6'd9, 6'd0, 6'd0, 1'b0}));
    send_byte(8'h55);
    check("b_overrun", 32'(err_overrun), 32'd1);
    check("b_mv_hold", 32'(move_valid), 32'd1);
    idle(1);
    check("b_overrun_pulse", 32'(err_overrun), 32'd0);
    idle(3);
    check("b_hold_stable", 32'({move_valid, x_1, y_1, x_2, y_2, stones}),
          32'({1'b1, 6'd9, 6'd9, 6'd0, 6'd0, 1'b0}));
    board_ready = 1'b1;
    idle(1);
    check("b_mv_fall", 32'(move_valid), 32'd0);
    idle(1);
    check("b_mv_cycles", 32'(mv_cnt), 32'd7);
    check("b_ovr_count", 32'(ovr_cnt), 32'd1);

    // Format errors: X1 = 19, COUNT = 3, duplicate stone
    send_pkt({8'hA5, 8'h02, 8'h13, 40'h0}, 3);
    check("c_fmt_range", 32'({err_format, move_valid}), 32'({1'b1, 1'b0}));
    idle(1);
    send_byte(8'h00);
    idle(1);
    send_pkt({8'hA5, 8'h03, 48'h0}, 2);
    check("c_fmt_count", 32'(err_format), 32'd1);
    idle(1);
    send_pkt({8'hA5, 8'h02, 8'h05, 8'h05, 8'h05, 8'h05, 16'h0}, 6);
    check("c_fmt_dup", 32'(err_format), 32'd1);
    idle(2);
    check("c_fmt_count_total", 32'(fmt_cnt), 32'd3);
    check("c_no_mv", 32'(mv_cnt), 32'd7);
    send_pkt({8'hA5, 8'h01, 8'h00, 8'h12, 8'hB6, 24'h0}, 5);
    check("c_good_mv", 32'(move_valid), 32'd1);
    check("c_good_coords", 32'({x_1, y_1, x_2, y_2, stones}),
          32'({6'd0, 6'd18, 6'd0, 6'd0, 1'b0}));
    idle(2);

    // Checksum error leaves outputs untouched
    send_pkt({8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA2, 8'h00}, 7);
    check("d_chk_err", 32'({err_checksum, move_valid}), 32'({1'b1, 1'b0}));
    check("d_outs_kept", 32'({x_1, y_1, x_2, y_2, stones}),
          32'({6'd0, 6'd18, 6'd0, 6'd0, 1'b0}));
    idle(2);
    check("d_counts", 32'({chk_cnt[7:0], mv_cnt[7:0]}), 32'({8'd1, 8'd8}));

    // Timeout after TO idle cycles
    send_pkt({8'hA5, 8'h02, 8'h05, 40'h0}, 3);
    idle(TO);
    check("e_not_early", 32'(err_timeout), 32'd0);
    idle(1);
    check("e_timeout", 32'(err_timeout), 32'd1);
    idle(1);
    check("e_timeout_pulse", 32'(err_timeout), 32'd0);

    // Byte arriving exactly at expiry is accepted
    send_pkt({8'hA5, 8'h02, 8'h05, 40'h0}, 3);
    idle(TO);
    send_byte(8'h06);
    check("e_byte_wins", 32'(err_timeout), 32'd0);
    idle(1);
    send_pkt({8'h07, 8'h08, 8'hAB, 40'h0}, 3);
    check("e_late_mv", 32'(move_valid), 32'd1);
    check("e_late_coords", 32'({x_1, y_1, x_2, y_2, stones}),
          32'({6'd5, 6'd6, 6'd7, 6'd8, 1'b1}));
    idle(2);
    check("e_counts", 32'({to_cnt[7:0], mv_cnt[7:0]}), 32'({8'd1, 8'd9}));

    // Reset mid-packet
    send_pkt({8'hA5, 8'h02, 8'h01, 40'h0}, 3);
    reset = 1'b1;
    #1;
    check("f_async_clear", 32'({x_1, y_1, x_2, y_2, stones, move_valid,
          err_format, err_checksum, err_timeout, err_overrun}), 32'd0);
    idle(2);
    reset = 1'b0;
    idle(3);
    check("f_no_pulses", 32'({fmt_cnt[7:0], chk_cnt[7:0], to_cnt[7:0], ovr_cnt[7:0]}),
          32'({8'd3, 8'd1, 8'd1, 8'd1}));
    check("f_no_mv", 32'(mv_cnt), 32'd9);
    send_pkt({8'hA5, 8'h01, 8'h12, 8'h00, 8'hB6, 24'h0}, 5);
    check("f_next_mv", 32'(move_valid), 32'd1);
    check("f_next_coords", 32'({x_1, y_1, x_2, y_2, stones}),
          32'({6'd18, 6'd0, 6'd0, 6'd0, 1'b0}));
    idle(2);
    check("f_mv_fall", 32'(move_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
